// File: rtl/branch_predict_resolve.sv
// Branch resolution in EX with a 2-bit saturating BHT for IF direction
// prediction, registered EX/MEM results, mispredict redirect and
// saturating performance counters.
module branch_predict_resolve #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned BHT_IDX_W = 6,
    parameter int unsigned CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    // IF-side prediction lookup
    input  logic [XLEN-1:0]  if_pc,
    output logic             if_pred_taken,
    // EX-side resolution inputs
    input  logic             ex_valid,
    input  logic             ex_stall,
    input  logic [2:0]       branch_ctrl,
    input  logic [2:0]       func3,
    input  logic [XLEN-1:0]  data1,
    input  logic [XLEN-1:0]  data2,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [XLEN-1:0]  ex_imm,
    input  logic             ex_pred_taken,
    // Registered EX/MEM results
    output logic             res_valid,
    output logic [3:0]       branch_type,
    output logic             res_taken,
    output logic [XLEN-1:0]  res_target,
    output logic             res_mispredict,
    output logic [XLEN-1:0]  res_redirect_pc,
    output logic [CNT_W-1:0] cnt_branches,
    output logic [CNT_W-1:0] cnt_mispred
);

    localparam int unsigned BHT_ENTRIES = 1 << BHT_IDX_W;
    localparam int unsigned IDX_LO      = 2;
    localparam int unsigned IDX_HI      = BHT_IDX_W + 1;

    localparam logic [2:0] CTRL_COND = 3'b001;
    localparam logic [2:0] CTRL_JAL  = 3'b010;
    localparam logic [2:0] CTRL_JALR = 3'b100;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [3:0] BT_NONE     = 4'b0000;
    localparam logic [3:0] BT_COND_NT  = 4'b0001;
    localparam logic [3:0] BT_COND_TK  = 4'b0010;
    localparam logic [3:0] BT_JAL      = 4'b0100;
    localparam logic [3:0] BT_JALR     = 4'b1000;

    localparam logic [1:0] BHT_INIT    = 2'b01;
    localparam logic [1:0] BHT_MAX     = 2'b11;
    localparam logic [1:0] BHT_MIN     = 2'b00;

    // Registered EX/MEM result payload
    typedef struct packed {
        logic            valid;
        logic [3:0]      btype;
        logic            taken;
        logic [XLEN-1:0] target;
        logic            mispredict;
        logic [XLEN-1:0] redirect;
    } res_t;

    logic [1:0]           bht_q [BHT_ENTRIES];
    logic [BHT_IDX_W-1:0] if_idx;
    logic [BHT_IDX_W-1:0] ex_idx;

    logic                 is_cond;
    logic                 is_jal;
    logic                 is_jalr;
    logic                 fire;
    logic                 cond_taken;

    logic [XLEN-1:0]      pc_target;
    logic [XLEN-1:0]      jalr_sum;
    logic [XLEN-1:0]      jalr_target;
    logic [XLEN-1:0]      fallthrough;

    res_t                 res_d;
    res_t                 res_q;
    logic [CNT_W-1:0]     cnt_branches_q;
    logic [CNT_W-1:0]     cnt_mispred_q;

    logic                 unused_bits;

    // Index extraction and prediction read (pre-update value, no bypass)
    assign if_idx        = if_pc[IDX_HI:IDX_LO];
    assign ex_idx        = ex_pc[IDX_HI:IDX_LO];
    assign if_pred_taken = bht_q[if_idx][1];

    // Only addressing bits of the fetch PC feed the table
    assign unused_bits = ^{if_pc[XLEN-1:IDX_HI+1], if_pc[IDX_LO-1:0], jalr_sum[0]};

    // Decode: illegal one-hot codes behave as "no branch"
    assign is_cond = (branch_ctrl == CTRL_COND);
    assign is_jal  = (branch_ctrl == CTRL_JAL);
    assign is_jalr = (branch_ctrl == CTRL_JALR);
    assign fire    = ex_valid & ~ex_stall & (is_cond | is_jal | is_jalr);

    // Target arithmetic, all modulo 2^XLEN
    assign pc_target   = ex_pc + ex_imm;
    assign jalr_sum    = data1 + ex_imm;
    assign jalr_target = {jalr_sum[XLEN-1:1], 1'b0};
    assign fallthrough = ex_pc + XLEN'(4);

    // Conditional branch evaluation; reserved func3 codes resolve not-taken
    always_comb begin
        cond_taken = 1'b0;
        case (func3)
            F3_BEQ:  cond_taken = (data1 == data2);
            F3_BNE:  cond_taken = (data1 != data2);
            F3_BLT:  cond_taken = ($signed(data1) <  $signed(data2));
            F3_BGE:  cond_taken = ($signed(data1) >= $signed(data2));
            F3_BLTU: cond_taken = (data1 <  data2);
            F3_BGEU: cond_taken = (data1 >= data2);
            default: cond_taken = 1'b0;
        endcase
    end

    // Next result: zero unless a legal branch fires this cycle
    always_comb begin
        res_d = '0;
        if (fire) begin
            res_d.valid = 1'b1;
            if (is_cond) begin
                res_d.taken      = cond_taken;
                res_d.btype      = cond_taken ? BT_COND_TK : BT_COND_NT;
                res_d.target     = pc_target;
                res_d.mispredict = (cond_taken != ex_pred_taken);
            end else if (is_jal) begin
                res_d.taken      = 1'b1;
                res_d.btype      = BT_JAL;
                res_d.target     = pc_target;
                res_d.mispredict = ~ex_pred_taken;
            end else begin
                // No BTB, so the JALR target is never known in IF
                res_d.taken      = 1'b1;
                res_d.btype      = BT_JALR;
                res_d.target     = jalr_target;
                res_d.mispredict = 1'b1;
            end
            if (res_d.mispredict) begin
                res_d.redirect = res_d.taken ? res_d.target : fallthrough;
            end
        end else begin
            res_d.btype = BT_NONE;
        end
    end

    // EX/MEM result register; holds while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            res_q <= '0;
        end else if (!ex_stall) begin
            res_q <= res_d;
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_branches_q <= '0;
            cnt_mispred_q  <= '0;
        end else begin
            if (fire && is_cond && (cnt_branches_q != '1)) begin
                cnt_branches_q <= cnt_branches_q + CNT_W'(1);
            end
            if (fire && res_d.mispredict && (cnt_mispred_q != '1)) begin
                cnt_mispred_q <= cnt_mispred_q + CNT_W'(1);
            end
        end
    end

    // BHT training on conditional fires only, saturating at both ends
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(BHT_ENTRIES); i++) begin
                bht_q[i] <= BHT_INIT;
            end
        end else if (fire && is_cond) begin
            if (cond_taken) begin
                if (bht_q[ex_idx] != BHT_MAX) begin
                    bht_q[ex_idx] <= bht_q[ex_idx] + 2'd1;
                end
            end else begin
                if (bht_q[ex_idx] != BHT_MIN) begin
                    bht_q[ex_idx] <= bht_q[ex_idx] - 2'd1;
                end
            end
        end
    end

    // Output mapping
    assign res_valid       = res_q.valid;
    assign branch_type     = res_q.btype;
    assign res_taken       = res_q.taken;
    assign res_target      = res_q.target;
    assign res_mispredict  = res_q.mispredict;
    assign res_redirect_pc = res_q.redirect;
    assign cnt_branches    = cnt_branches_q;
    assign cnt_mispred     = cnt_mispred_q;

endmodule
